// File: rtl/nvram_backup_pkg.sv
// Shared types and helpers for the NVRAM save-image backup engine.
package nvram_backup_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } bk_state_e;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_SHIFT = $clog2(SECTOR_BYTES);

  // Sectors needed to hold an image of 'size' bytes, rounded up and
  // clamped to the NVRAM capacity. Computed at 33 bits so sizes close to
  // 4 GB do not wrap during the round-up.
  function automatic logic [31:0] img_sectors(input logic [31:0] size,
                                              input int unsigned max_sec);
    logic [32:0] n;
    n = ({1'b0, size} + 33'(SECTOR_BYTES - 1)) >> SECTOR_SHIFT;
    if (n > 33'(max_sec)) n = 33'(max_sec);
    return n[31:0];
  endfunction

endpackage

// File: rtl/nvram_backup_if.sv
// SD sector request/acknowledge bundle between the backup engine and user_io.
interface nvram_backup_if #(parameter int LBA_W = 32);
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/nvram_autosave_timer.sv
// Dirty flag plus quiet-frame counter; raises auto_save once the game has
// left a dirty NVRAM untouched for AUTOSAVE_FRAMES frames.
module nvram_autosave_timer #(
  parameter int AUTOSAVE_FRAMES = 3
) (
  input  logic clk_sys,
  input  logic RESET_n,
  input  logic nvram_we,
  input  logic frame,
  input  logic dl_rise,
  input  logic save_start,
  input  logic dirty_clr,
  output logic dirty,
  output logic auto_save
);
  localparam int W = $clog2(AUTOSAVE_FRAMES + 1);
  localparam logic [W-1:0] LIMIT = W'(AUTOSAVE_FRAMES);

  logic [W-1:0] quiet;

  // Quiet counter: restarts on every write and on save start, saturates.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)                   quiet <= '0;
    else if (save_start)            quiet <= '0;
    else if (nvram_we)              quiet <= '0;
    else if (frame && quiet != LIMIT) quiet <= quiet + 1'b1;
  end

  // Dirty: a ROM download discards the image; a write always wins over a
  // completion clear so nothing written late is lost.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)       dirty <= 1'b0;
    else if (dl_rise)   dirty <= 1'b0;
    else if (nvram_we)  dirty <= 1'b1;
    else if (dirty_clr) dirty <= 1'b0;
  end

  assign auto_save = dirty & (quiet == LIMIT);

endmodule

// File: rtl/nvram_backup.sv
// Save-RAM backup engine: loads a mounted save image into NVRAM sector by
// sector, resets the core afterwards, and writes NVRAM back on request or
// after a quiet period.
module nvram_backup
  import nvram_backup_pkg::*;
#(
  parameter int SECTORS_LOG2    = 4,
  parameter int LBA_W           = 32,
  parameter int AUTOSAVE_FRAMES = 0
) (
  input  logic                  clk_sys,
  input  logic                  RESET_n,
  input  logic                  img_mounted,
  input  logic [31:0]           img_size,
  input  logic                  download,
  input  logic                  save_req,
  input  logic                  frame,
  input  logic                  nvram_we,
  nvram_backup_if.master        sd,
  output logic                  bk_ena,
  output logic                  busy,
  output logic                  dirty,
  output logic                  bk_reset
);
  localparam int unsigned NSEC = 2 ** SECTORS_LOG2;

  bk_state_e state, state_nxt;

  logic                    mnt_q, save_q, dl_q, ack_q;
  logic                    mnt_rise, save_rise, dl_rise, ack_rise, ack_fall;
  logic [SECTORS_LOG2-1:0] lba, cnt_last;
  logic                    is_load, abort, we_seen;
  logic                    load_go, save_go, auto_save, last_sec;
  logic                    done_ok, dirty_clr;
  logic [31:0]             n_load;

  assign mnt_rise  = img_mounted & ~mnt_q;
  assign save_rise = save_req & ~save_q;
  assign dl_rise   = download & ~dl_q;
  assign ack_rise  = sd.sd_ack & ~ack_q;
  assign ack_fall  = ~sd.sd_ack & ack_q;

  assign n_load   = img_sectors(img_size, NSEC);
  assign load_go  = (state == IDLE) & mnt_rise & (img_size != 32'd0);
  // Load has priority; a save arriving in the same cycle is dropped.
  assign save_go  = (state == IDLE) & bk_ena & (save_rise | auto_save) & ~load_go;
  assign last_sec = (lba == cnt_last);
  assign done_ok  = (state == DONE) & ~abort;
  assign dirty_clr = done_ok & ~we_seen;

  // Registered copies of the inputs for edge detection.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      mnt_q  <= 1'b0;
      save_q <= 1'b0;
      dl_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      mnt_q  <= img_mounted;
      save_q <= save_req;
      dl_q   <= download;
      ack_q  <= sd.sd_ack;
    end
  end

  // Image-valid flag: set by a non-empty mount, dropped by an empty mount
  // or by a ROM download (download wins if both happen together).
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)      bk_ena <= 1'b0;
    else if (dl_rise)  bk_ena <= 1'b0;
    else if (mnt_rise) bk_ena <= (img_size != 32'd0);
  end

  // State register.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: one ISSUE/XFER round per sector.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_go || save_go) state_nxt = ISSUE;
      ISSUE:   if (ack_rise)           state_nxt = XFER;
      XFER:    if (ack_fall)           state_nxt = (abort || last_sec) ? DONE : ISSUE;
      DONE:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Transfer context: sector pointer, direction, length, abort and
  // write-during-transfer tracking.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      lba      <= '0;
      cnt_last <= '0;
      is_load  <= 1'b0;
      abort    <= 1'b0;
      we_seen  <= 1'b0;
    end else if (load_go || save_go) begin
      lba      <= '0;
      is_load  <= load_go;
      cnt_last <= load_go ? SECTORS_LOG2'(n_load - 32'd1) : '1;
      abort    <= 1'b0;
      we_seen  <= nvram_we;
    end else begin
      if (state == XFER && ack_fall && !abort && !last_sec) lba <= lba + 1'b1;
      if (state != IDLE && dl_rise)  abort   <= 1'b1;
      if (state != IDLE && nvram_we) we_seen <= 1'b1;
    end
  end

  // Outputs decoded from state so a reset drops the request immediately.
  always_comb begin
    sd.sd_lba = LBA_W'(lba);
    sd.sd_rd  = 1'b0;
    sd.sd_wr  = 1'b0;
    bk_reset  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      ISSUE: begin
        sd.sd_rd = is_load;
        sd.sd_wr = ~is_load;
      end
      DONE:    bk_reset = is_load & ~abort;
      default: ;
    endcase
  end

  generate
    if (AUTOSAVE_FRAMES != 0) begin : g_auto
      nvram_autosave_timer #(
        .AUTOSAVE_FRAMES(AUTOSAVE_FRAMES)
      ) u_timer (
        .clk_sys    (clk_sys),
        .RESET_n    (RESET_n),
        .nvram_we   (nvram_we),
        .frame      (frame),
        .dl_rise    (dl_rise),
        .save_start (save_go),
        .dirty_clr  (dirty_clr),
        .dirty      (dirty),
        .auto_save  (auto_save)
      );
    end else begin : g_manual
      logic frame_unused;
      assign frame_unused = frame;
      assign auto_save    = 1'b0;

      // Dirty flag without autosave; same priorities as the timer.
      always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n)       dirty <= 1'b0;
        else if (dl_rise)   dirty <= 1'b0;
        else if (nvram_we)  dirty <= 1'b1;
        else if (dirty_clr) dirty <= 1'b0;
      end
    end
  endgenerate

endmodule
